// File: rtl/deinterleaver.sv
// Receive-side block deinterleaver. It writes each bit at its original position k(j) in one of
// two banks (ping-pong) and streams every complete block out in order k = 0..NCBPS-1.
module deinterleaver #(
    parameter int NCBPS = 192,
    parameter int NCPC  = 2,
    parameter int D     = 16
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     valid_demod,
    input  logic                     data_in,
    input  logic                     ready_fec,
    output logic                     ready_deinterleaver,
    output logic                     valid_deinterleaver,
    output logic                     data_out,
    output logic [$clog2(NCBPS)-1:0] data_out_index
);
    localparam int S  = (NCPC / 2 > 1) ? NCPC / 2 : 1;
    localparam int W  = $clog2(NCBPS);
    // MW holds D*m for m up to NCBPS-1, so the mapping arithmetic never truncates.
    localparam int MW = $clog2(D * NCBPS);
    localparam logic [W-1:0] LAST = W'(NCBPS - 1);

    function automatic logic [MW-1:0] map_k(input logic [W-1:0] j);
        logic [MW-1:0] jw;
        logic [MW-1:0] m;
        logic [MW-1:0] dm;
        jw = MW'(j);
        m  = MW'(S) * (jw / MW'(S)) + ((jw + (MW'(D) * jw) / MW'(NCBPS)) % MW'(S));
        dm = MW'(D) * m;
        return dm - MW'(NCBPS - 1) * (dm / MW'(NCBPS));
    endfunction

    logic [1:0][NCBPS-1:0] bank_q;
    logic [1:0]            full_q, full_d;
    logic [W-1:0]          wr_cnt_q, wr_cnt_d;
    logic [W-1:0]          rd_cnt_q, rd_cnt_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  wr_fire, rd_fire;
    logic [MW-1:0]         wr_k;

    assign ready_deinterleaver = !full_q[wr_bank_q];
    assign valid_deinterleaver = full_q[rd_bank_q];
    assign data_out            = bank_q[rd_bank_q][rd_cnt_q];
    assign data_out_index      = rd_cnt_q;

    assign wr_fire = valid_demod && ready_deinterleaver;
    assign rd_fire = valid_deinterleaver && ready_fec;
    assign wr_k    = map_k(wr_cnt_q);

    // The write bank is never full and the read bank is always full when active,
    // so a completing write and a completing read always touch different flags.
    always_comb begin
        full_d    = full_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (wr_fire) begin
            if (wr_cnt_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_cnt_d          = '0;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
        if (rd_fire) begin
            if (rd_cnt_q == LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_cnt_d          = '0;
                rd_bank_d         = !rd_bank_q;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            full_q    <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Bank storage is deliberately not reset; a discarded partial block is simply overwritten.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < NCBPS; i++) begin
                if (wr_k == MW'(i)) begin
                    bank_q[wr_bank_q][i] <= data_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_deinterleaver.sv
// Scoreboard bench for deinterleaver: drivers push the expected output stream,
// and a negedge monitor pops and compares every output beat.
module tb_deinterleaver;
    localparam int N = 192;
    localparam logic [N-1:0] GOLD_IN  = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;
    localparam logic [N-1:0] GOLD_OUT = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

    typedef struct packed {
        logic [7:0] idx;
        logic       b;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       valid_demod;
    logic       data_in;
    logic       ready_fec;
    logic       ready_deinterleaver;
    logic       valid_deinterleaver;
    logic       data_out;
    logic [7:0] data_out_index;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   jmap[N];
    bit   watch_ready = 0;
    int   ready_drops = 0;
    bit   t5_done;

    deinterleaver dut (
        .clk                 (clk),
        .resetN              (resetN),
        .valid_demod         (valid_demod),
        .data_in             (data_in),
        .ready_fec           (ready_fec),
        .ready_deinterleaver (ready_deinterleaver),
        .valid_deinterleaver (valid_deinterleaver),
        .data_out            (data_out),
        .data_out_index      (data_out_index)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetN && valid_deinterleaver && ready_fec) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected idx=%0d data=%0b required no output", data_out_index, data_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (data_out_index !== mon_e.idx || data_out !== mon_e.b) begin
                    errors++;
                    $display("FAIL out_beat idx=%0d data=%0b required idx=%0d data=%0b",
                             data_out_index, data_out, mon_e.idx, mon_e.b);
                end
            end
        end
        if (watch_ready && !ready_deinterleaver) ready_drops++;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
    task automatic send_bit(input logic b);
        int  t;
        bit  done;
        t = 0;
        done = 0;
        valid_demod = 1'b1;
        data_in     = b;
        while (!done) begin
            @(negedge clk);
            if (ready_deinterleaver) done = 1;
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 5000) begin
                $display("FAIL send_timeout actual=stalled required=accepted");
                $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
                $fatal(1);
            end
        end
        valid_demod = 1'b0;
    endtask

    task automatic send_bits(input logic [N-1:0] blk, input int count, input int gap_max);
        for (int j = 0; j < count; j++) begin
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(0, gap_max);
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_bit(blk[N-1-j]);
        end
    endtask

    task automatic push_model(input logic [N-1:0] blk);
        for (int k = 0; k < N; k++) exp_q.push_back({8'(k), blk[N-1-jmap[k]]});
    endtask

    task automatic push_golden();
        logic [N-1:0] g;
        g = GOLD_OUT;
        for (int k = 0; k < N; k++) exp_q.push_back({8'(k), g[N-1-k]});
    endtask

    task automatic push_onehot(input int kk);
        for (int k = 0; k < N; k++) exp_q.push_back({8'(k), (k == kk) ? 1'b1 : 1'b0});
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic rand_block(output logic [N-1:0] r);
        for (int w = 0; w < N / 32; w++) r[w*32 +: 32] = $urandom();
    endtask

    initial begin
        logic [N-1:0] blk;
        logic [N-1:0] blk_b;
        int           spot_j[4];
        int           spot_k[4];

        // Model: k = 16j - 191*(j/12) for QPSK; inverse table j of k.
        for (int j = 0; j < N; j++) jmap[16*j - 191*(j/12)] = j;
        spot_j = '{0, 1, 12, 191};
        spot_k = '{0, 16, 1, 191};

        resetN      = 1'b0;
        valid_demod = 1'b0;
        data_in     = 1'b0;
        ready_fec   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", int'(valid_deinterleaver), 0);
        chk("reset_ready", int'(ready_deinterleaver), 1);
        chk("reset_index", int'(data_out_index), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;

        // Golden block
        send_bits(GOLD_IN, N, 0);
        push_golden();
        drain("golden_drain");

        // One-hot mapping spot checks
        for (int i = 0; i < 4; i++) begin
            blk = '0;
            blk[N-1-spot_j[i]] = 1'b1;
            send_bits(blk, N, 0);
            push_onehot(spot_k[i]);
        end
        drain("spot_drain");

        // Ten back-to-back blocks at full rate
        watch_ready = 1;
        for (int b = 0; b < 10; b++) begin
            send_bits(GOLD_IN, N, 0);
            push_golden();
        end
        watch_ready = 0;
        chk("b2b_ready_drops", ready_drops, 0);
        drain("b2b_drain");

        // Downstream stalled: both banks fill, then input is refused
        ready_fec = 1'b0;
        blk_b = ~GOLD_IN;
        send_bits(GOLD_IN, N, 0);
        push_golden();
        send_bits(blk_b, N, 0);
        push_model(blk_b);
        @(negedge clk);
        chk("stall_ready_low", int'(ready_deinterleaver), 0);
        chk("stall_valid_high", int'(valid_deinterleaver), 1);
        chk("stall_index_hold", int'(data_out_index), 0);
        @(posedge clk);
        #1;
        valid_demod = 1'b1;
        data_in     = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("stall_ready_still_low", int'(ready_deinterleaver), 0);
        chk("stall_index_still_0", int'(data_out_index), 0);
        @(posedge clk);
        #1;
        valid_demod = 1'b0;
        ready_fec   = 1'b1;
        drain("stall_drain");
        @(negedge clk);
        chk("stall_ready_back", int'(ready_deinterleaver), 1);
        @(posedge clk);
        #1;

        // Random valid_demod / ready_fec gaps over five blocks
        t5_done = 0;
        fork
            begin
                for (int b = 0; b < 5; b++) begin
                    rand_block(blk);
                    send_bits(blk, N, 3);
                    push_model(blk);
                end
                t5_done = 1;
            end
            begin
                while (!t5_done) begin
                    @(posedge clk);
                    #1;
                    ready_fec = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_fec = 1'b1;
        drain("gaps_drain");

        // Reset mid-block: partial block discarded, next block correct from k0
        send_bits(GOLD_IN, N, 0);
        push_golden();
        send_bits(blk_b, 100, 0);
        resetN = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        chk("midreset_valid", int'(valid_deinterleaver), 0);
        chk("midreset_ready", int'(ready_deinterleaver), 1);
        chk("midreset_index", int'(data_out_index), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        rand_block(blk);
        send_bits(blk, N, 0);
        push_model(blk);
        drain("postreset_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
